// File: rtl/mips_run_ctrl.sv
// Execution controller for the single-cycle MIPS core: gates the core clock enable for
// counted runs, breakpoint runs and single-stepping, and records retired PC/ALU pairs in a circular trace.
module mips_run_ctrl #(
    parameter int PC_W        = 6,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [1:0]                     mode,
    input  logic [CNT_W-1:0]               num_instr,
    input  logic [PC_W-1:0]                bp_addr,
    input  logic                           bp_en,
    input  logic                           step,
    input  logic                           abort,
    input  logic [PC_W-1:0]                pc_in,
    input  logic [DATA_W-1:0]              alu_in,
    output logic                           cpu_en,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     halt_cause,
    output logic [CNT_W-1:0]               instr_count,
    input  logic                           trd_en,
    output logic                           trd_valid,
    output logic [PC_W-1:0]                trd_pc,
    output logic [DATA_W-1:0]              trd_data,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic                           trace_overflow
);

    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] MODE_RUN_BP = 2'b01;
    localparam logic [1:0] MODE_STEP   = 2'b10;

    localparam logic [1:0] CAUSE_COUNT = 2'b01;
    localparam logic [1:0] CAUSE_BP    = 2'b10;
    localparam logic [1:0] CAUSE_ABORT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  limit_q;
    logic [PC_W-1:0]   bp_addr_q;
    logic              bp_en_q;
    logic              mode_bp_q;
    logic              zero_unlim_q;
    logic              first_q;

    logic              start_ok;
    logic              limit_hit;
    logic              bp_hit;
    logic              halt;

    logic [PC_W+DATA_W-1:0] mem [TRACE_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   full;
    logic                   pop;

    assign start_ok = start && (state == S_IDLE || state == S_DONE);

    // A zero limit means "no limit" only in breakpoint and step runs; RUN_N with zero halts at once.
    always_comb begin
        limit_hit = (instr_count == limit_q) && ((limit_q != '0) || !zero_unlim_q);
        bp_hit    = mode_bp_q && bp_en_q && (pc_in == bp_addr_q) && !first_q;
        halt      = abort || limit_hit || bp_hit;
        cpu_en    = 1'b0;
        case (state)
            S_RUN:   cpu_en = !halt;
            S_STEP:  cpu_en = step && !abort && !limit_hit;
            default: cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            halt_cause   <= 2'b00;
            instr_count  <= '0;
            limit_q      <= '0;
            bp_addr_q    <= '0;
            bp_en_q      <= 1'b0;
            mode_bp_q    <= 1'b0;
            zero_unlim_q <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            if (cpu_en)
                instr_count <= instr_count + CNT_W'(1);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        limit_q      <= num_instr;
                        bp_addr_q    <= bp_addr;
                        bp_en_q      <= bp_en;
                        mode_bp_q    <= (mode == MODE_RUN_BP);
                        zero_unlim_q <= (mode == MODE_RUN_BP) || (mode == MODE_STEP);
                        first_q      <= 1'b1;
                        instr_count  <= '0;
                        halt_cause   <= 2'b00;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        state        <= (mode == MODE_STEP) ? S_STEP : S_RUN;
                    end
                end
                S_RUN: begin
                    first_q <= 1'b0;
                    if (halt) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        halt_cause <= abort ? CAUSE_ABORT : (limit_hit ? CAUSE_COUNT : CAUSE_BP);
                    end
                end
                S_STEP: begin
                    first_q <= 1'b0;
                    if (abort || limit_hit) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        halt_cause <= abort ? CAUSE_ABORT : CAUSE_COUNT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign full = (trace_count == CW'(TRACE_DEPTH));
    assign pop  = trd_en && (trace_count != '0);

    // Trace storage carries data only; validity lives in the pointers and count.
    always_ff @(posedge clk) begin
        if (cpu_en)
            mem[wr_ptr] <= {pc_in, alu_in};
    end

    // Pop is applied before the write, so a full buffer that pops and writes together loses nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            trace_count    <= '0;
            trace_overflow <= 1'b0;
            trd_valid      <= 1'b0;
            trd_pc         <= '0;
            trd_data       <= '0;
        end else if (start_ok) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            trace_count    <= '0;
            trace_overflow <= 1'b0;
            trd_valid      <= 1'b0;
        end else begin
            trd_valid <= pop;
            if (pop)
                {trd_pc, trd_data} <= mem[rd_ptr];
            case ({pop, cpu_en})
                2'b10: begin
                    rd_ptr      <= rd_ptr + AW'(1);
                    trace_count <= trace_count - CW'(1);
                end
                2'b01: begin
                    wr_ptr <= wr_ptr + AW'(1);
                    if (full) begin
                        rd_ptr         <= rd_ptr + AW'(1);
                        trace_overflow <= 1'b1;
                    end else begin
                        trace_count <= trace_count + CW'(1);
                    end
                end
                2'b11: begin
                    rd_ptr <= rd_ptr + AW'(1);
                    wr_ptr <= wr_ptr + AW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
